stepper_sequencer: RTL and testbench
====================================

# stepper_sequencer

Parametrised single-channel stepper-motor sequencer driving four coil outputs with selectable wave, full and half-step excitation. It combines these functions in one block:
- a speed prescaler selected by a 2-bit code;
- continuous run under `enable`;
- counted moves with a completion pulse;
- a wrapping signed position counter.

It sits between the board switch/button conditioning logic and the coil driver pins, and is the generalised successor of the fixed full-step coil FSM.

## Interface
Parameters:
- `BASE_PERIOD`, default 1_250_000. Clock cycles per step at `motorSpeed`=3.
- `PRESCALE_WIDTH`, default 24. Prescaler width. Must satisfy `BASE_PERIOD*8-1 < 2^PRESCALE_WIDTH`.
- `COUNT_WIDTH`, default 16. Width of the move step counter.
- `POS_WIDTH`, default 16. Width of the signed position counter.
- `HOLD_TORQUE`, default 1. 1 = coils keep the last pattern when stopped; 0 = coils go to 0000 when stopped.

Ports:
- `clock`  in  1  single system clock. All logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  continuous-run request.
- `direction`  in  1  1 = forward (phase index increasing), 0 = reverse.
- `stepMode`  in  2  00 wave, 01 full, 10 half, 11 treated as full.
- `motorSpeed`  in  2  step period = `BASE_PERIOD << (3 - motorSpeed)`.
- `moveStart`  in  1  single-cycle request to begin a counted move.
- `moveSteps`  in  `COUNT_WIDTH`  step count, sampled on an accepted `moveStart`.
- `lights`  out  4  coil drive pattern.
- `stepPulse`  out  1  high for one cycle on each cycle in which a step is taken.
- `busy`  out  1  high in RUN or MOVE.
- `moveDone`  out  1  one-cycle pulse at the end of a counted move.
- `position`  out  `POS_WIDTH`  signed step count.

## Operation
- Phase index `idx` is 3 bits. Pattern table, idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Half mode: `idx` ± 1 mod 8.
- Wave and full modes: `next = ((idx ± 2) & 3'b110) | p`, where p = 0 for wave and 1 for full.
  - This realigns parity on the first step after a mode change.
- `position` changes by +1 (forward) or −1 (reverse) on every step in every mode. It wraps modulo 2^`POS_WIDTH`.
- FSM states:
  - IDLE: `busy`=0, no steps. `lights` = `pattern[idx]` if `HOLD_TORQUE`, else 0000.
    - An accepted `moveStart` loads `remaining` = `moveSteps` and goes to MOVE.
    - Otherwise `enable`=1 goes to RUN.
    - `moveStart` has priority over `enable` when both are asserted in the same cycle.
  - RUN: steps on every prescaler tick. `enable`=0 returns to IDLE on the next edge with no further step. `moveStart` is ignored in RUN.
  - MOVE: steps on tick and decrements `remaining`.
    - On the step that takes `remaining` 1→0, the next state is DONE.
    - `enable` and `moveStart` are ignored in MOVE.
    - `moveSteps`=0 goes straight to DONE on the next edge with no step.
  - DONE: `moveDone`=1 for exactly one cycle, `busy`=0, then IDLE.
- `direction` and `stepMode` are sampled at each step. Changing them mid-run takes effect on the next step.

## Timing
- Reset (`reset`=0, asynchronous) forces:
  - `idx`=0, `position`=0, state IDLE;
  - `lights`=0000 regardless of `HOLD_TORQUE`;
  - `stepPulse`=0, `busy`=0, `moveDone`=0.
- Prescaler:
  - Clears to 0 on entry to RUN or MOVE.
  - Counts to P−1, then issues a tick and reloads.
  - The first step occurs P cycles after the state-entry edge.
- Period P is latched at entry and at each tick. A `motorSpeed` change affects the interval after the next step.
- `lights`, `position`, `idx` and `stepPulse` update on the same edge (registered, zero extra latency).
- `busy` rises on the edge entering RUN or MOVE and falls on the edge leaving RUN or entering DONE.
- Reset asserted mid-move aborts with no `moveDone`.

## Test plan
All scenarios use `BASE_PERIOD`=2.
1. Reset, then `moveStart` with `moveSteps`=5, half mode, forward, speed 3:
   - 5 `stepPulse`s 2 cycles apart;
   - `lights` 1100, 0100, 0110, 0010, 0011;
   - `position`=5;
   - one `moveDone` pulse; `busy` low afterwards.
2. Wave mode, reverse, `enable`=1 for 7 steps, starting from idx 0:
   - `lights` sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100;
   - `position`=−7 (0xFFF9).
3. Mid-run switch from half (idx=3) to wave, forward:
   - next `lights`=0010 (idx 4);
   - then 0001.
4. Speed 0 vs speed 3 during RUN:
   - steps are 16 cycles apart at speed 0 and 2 cycles apart at speed 3;
   - a speed change made mid-interval applies from the following interval.
5. Boundary cases:
   - `moveSteps`=0 → `moveDone` 2 edges after `moveStart`, no `stepPulse`.
   - `moveStart` and `enable` in the same cycle → MOVE wins.
   - `moveStart` during MOVE is ignored.
6. With `HOLD_TORQUE`=0:
   - `lights`=0000 after `enable` falls.
   - With `POS_WIDTH`=4, 17 forward steps give `position`=1 (wrap).
   - Reset asserted during MOVE → all outputs at reset values immediately, no `moveDone`.

Source files
------------

// File: rtl/stepper_sequencer.sv
// -----------------------------------------------------------------------------
// stepper_sequencer
//
// Single-channel stepper-motor sequencer. Drives four coil outputs using wave,
// full or half-step excitation. Supports continuous run under `enable` and
// counted moves with a completion pulse. Keeps a wrapping signed position
// count. Step rate comes from a prescaler whose period is chosen by a 2-bit
// speed code.
//
// Parameters:
//   BASE_PERIOD     clock cycles per step at motorSpeed = 3
//   PRESCALE_WIDTH  prescaler width; BASE_PERIOD*8-1 must fit
//   COUNT_WIDTH     width of the counted-move step counter
//   POS_WIDTH       width of the signed position counter
//   HOLD_TORQUE     1: coils hold the last pattern when stopped, 0: release
//
// Ports:
//   clock       in   system clock, rising-edge logic
//   reset       in   asynchronous active-low reset
//   enable      in   continuous-run request
//   direction   in   1 = forward (phase index increasing), 0 = reverse
//   stepMode    in   00 wave, 01 full, 10 half, 11 full
//   motorSpeed  in   step period = BASE_PERIOD << (3 - motorSpeed)
//   moveStart   in   single-cycle request to begin a counted move
//   moveSteps   in   step count for a counted move
//   lights      out  coil drive pattern
//   stepPulse   out  high for the cycle following each step edge
//   busy        out  high while running or moving
//   moveDone    out  one-cycle pulse at the end of a counted move
//   position    out  signed, wrapping step count
// -----------------------------------------------------------------------------
module stepper_sequencer #(
    parameter int BASE_PERIOD    = 1_250_000,
    parameter int PRESCALE_WIDTH = 24,
    parameter int COUNT_WIDTH    = 16,
    parameter int POS_WIDTH      = 16,
    parameter bit HOLD_TORQUE    = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        direction,
    input  logic [1:0]                  stepMode,
    input  logic [1:0]                  motorSpeed,
    input  logic                        moveStart,
    input  logic [COUNT_WIDTH-1:0]      moveSteps,
    output logic [3:0]                  lights,
    output logic                        stepPulse,
    output logic                        busy,
    output logic                        moveDone,
    output logic signed [POS_WIDTH-1:0] position
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_MOVE = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE  = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PRE_BASE = PRESCALE_WIDTH'(BASE_PERIOD);
    localparam logic [COUNT_WIDTH-1:0]    REM_ONE  = COUNT_WIDTH'(1);
    localparam logic signed [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

    logic [1:0]                  state_q,  state_d;
    logic [2:0]                  idx_q,    idx_d;
    logic signed [POS_WIDTH-1:0] pos_q,    pos_d;
    logic [3:0]                  lights_q, lights_d;
    logic                        pulse_q,  pulse_d;
    logic [PRESCALE_WIDTH-1:0]   cnt_q,    cnt_d;
    logic [PRESCALE_WIDTH-1:0]   period_q, period_d;
    logic [COUNT_WIDTH-1:0]      rem_q,    rem_d;

    logic [PRESCALE_WIDTH-1:0]   period_sel;
    logic                        tick;
    logic                        take_step;
    logic                        stopped;

    // Coil pattern for each phase index; even indices are single-coil, odd
    // indices energise two adjacent coils.
    function automatic logic [3:0] coil_pattern(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b1000;
            3'd1:    p = 4'b1100;
            3'd2:    p = 4'b0100;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0010;
            3'd5:    p = 4'b0011;
            3'd6:    p = 4'b0001;
            default: p = 4'b1001;
        endcase
        return p;
    endfunction

    // Half mode walks every index. Wave/full move two indices and then force
    // the parity bit, so the first step after a mode change lands on the
    // correct (even = wave, odd = full) subset.
    function automatic logic [2:0] next_phase(input logic [2:0] i,
                                              input logic [1:0] mode,
                                              input logic       fwd);
        logic [2:0] stepped;
        if (mode == 2'b10) begin
            stepped = fwd ? (i + 3'd1) : (i - 3'd1);
        end else begin
            stepped = fwd ? (i + 3'd2) : (i - 3'd2);
            stepped = (stepped & 3'b110) | {2'b00, (mode != 2'b00)};
        end
        return stepped;
    endfunction

    assign period_sel = PRE_BASE << (2'd3 - motorSpeed);
    assign tick       = (cnt_q == (period_q - PRE_ONE));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        pulse_d   = 1'b0;
        cnt_d     = cnt_q;
        period_d  = period_q;
        rem_d     = rem_q;
        take_step = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (moveStart) begin
                    rem_d    = moveSteps;
                    period_d = period_sel;
                    state_d  = S_MOVE;
                end else if (enable) begin
                    period_d = period_sel;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    take_step = 1'b1;
                end else begin
                    cnt_d = cnt_q + PRE_ONE;
                end
            end
            S_MOVE: begin
                // A zero-length move finishes without stepping.
                if (rem_q == '0) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else if (tick) begin
                    take_step = 1'b1;
                    rem_d     = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + PRE_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Direction, mode and speed are all sampled at the step itself.
        if (take_step) begin
            idx_d    = next_phase(idx_q, stepMode, direction);
            pos_d    = direction ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
            pulse_d  = 1'b1;
            cnt_d    = '0;
            period_d = period_sel;
        end

        // The final step of a move is still shown; release happens on the
        // following edge when torque is not held.
        stopped = (state_d == S_IDLE) || (state_d == S_DONE);
        if (take_step) begin
            lights_d = coil_pattern(idx_d);
        end else if (stopped && !HOLD_TORQUE) begin
            lights_d = 4'b0000;
        end else begin
            lights_d = coil_pattern(idx_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            pos_q    <= '0;
            lights_q <= 4'b0000;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            period_q <= PRE_BASE;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pos_q    <= pos_d;
            lights_q <= lights_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            rem_q    <= rem_d;
        end
    end

    assign lights    = lights_q;
    assign stepPulse = pulse_q;
    assign position  = pos_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_MOVE);
    assign moveDone  = (state_q == S_DONE);

endmodule

// File: tb/tb_stepper_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stepper_sequencer
//
// Scoreboard bench for stepper_sequencer. Two instances with BASE_PERIOD = 2:
// dut (holding torque, 16-bit position) and dut2 (released coils, 4-bit
// position). Expected step results are queued when stimulus is applied and
// compared as each stepPulse appears.
// -----------------------------------------------------------------------------
module tb_stepper_sequencer;

    typedef struct {
        logic [3:0]  lights;
        logic [15:0] pos;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        enable, enable2;
    logic        direction;
    logic [1:0]  stepMode, motorSpeed;
    logic        moveStart, moveStart2;
    logic [15:0] moveSteps;

    logic [3:0]  lights, lights2;
    logic        stepPulse, stepPulse2;
    logic        busy, busy2;
    logic        moveDone, moveDone2;
    logic [15:0] position;
    logic [3:0]  position2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    stepper_sequencer #(
        .BASE_PERIOD(2), .PRESCALE_WIDTH(8), .COUNT_WIDTH(16),
        .POS_WIDTH(16), .HOLD_TORQUE(1'b1)
    ) dut (
        .clock(clk), .reset(rst_n), .enable(enable), .direction(direction),
        .stepMode(stepMode), .motorSpeed(motorSpeed), .moveStart(moveStart),
        .moveSteps(moveSteps), .lights(lights), .stepPulse(stepPulse),
        .busy(busy), .moveDone(moveDone), .position(position)
    );

    stepper_sequencer #(
        .BASE_PERIOD(2), .PRESCALE_WIDTH(8), .COUNT_WIDTH(16),
        .POS_WIDTH(4), .HOLD_TORQUE(1'b0)
    ) dut2 (
        .clock(clk), .reset(rst2_n), .enable(enable2), .direction(direction),
        .stepMode(stepMode), .motorSpeed(motorSpeed), .moveStart(moveStart2),
        .moveSteps(moveSteps), .lights(lights2), .stepPulse(stepPulse2),
        .busy(busy2), .moveDone(moveDone2), .position(position2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push1(input logic [3:0] l, input logic [15:0] p, input int g);
        exp_t e;
        e.lights = l;
        e.pos    = p;
        e.gap    = g;
        q1.push_back(e);
    endtask

    task automatic push2(input logic [3:0] l, input logic [15:0] p, input int g);
        exp_t e;
        e.lights = l;
        e.pos    = p;
        e.gap    = g;
        q2.push_back(e);
    endtask

    task automatic drain1(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q1.size() == 0) break;
            tick();
        end
        check_val({tag, "_drain"}, 32'(q1.size()), 32'd0);
    endtask

    task automatic drain2(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q2.size() == 0) break;
            tick();
        end
        check_val({tag, "_drain"}, 32'(q2.size()), 32'd0);
    endtask

    task automatic wait_done1(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (moveDone) break;
        end
        check_val({tag, "_done"}, 32'(moveDone), 32'd1);
        check_val({tag, "_done_busy"}, 32'(busy), 32'd0);
        tick();
        check_val({tag, "_done_1cyc"}, 32'(moveDone), 32'd0);
    endtask

    // Step monitor for dut
    initial begin : mon1
        exp_t e;
        int   last;
        last = 0;
        forever begin
            @(negedge clk);
            if (stepPulse) begin
                if (q1.size() == 0) begin
                    check_val("unexpected_step", 32'(stepPulse), 32'd0);
                end else begin
                    e = q1.pop_front();
                    check_val("step_lights", 32'(lights), 32'(e.lights));
                    check_val("step_pos", 32'(position), 32'(e.pos));
                    if (e.gap != 0) check_val("step_gap", 32'(cyc - last), 32'(e.gap));
                end
                last = cyc;
            end
        end
    end

    // Step monitor for dut2
    initial begin : mon2
        exp_t e;
        int   last;
        last = 0;
        forever begin
            @(negedge clk);
            if (stepPulse2) begin
                if (q2.size() == 0) begin
                    check_val("unexpected_step2", 32'(stepPulse2), 32'd0);
                end else begin
                    e = q2.pop_front();
                    check_val("step2_lights", 32'(lights2), 32'(e.lights));
                    check_val("step2_pos", 32'(position2), 32'(e.pos[3:0]));
                    if (e.gap != 0) check_val("step2_gap", 32'(cyc - last), 32'(e.gap));
                end
                last = cyc;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        logic [3:0] full_seq [4];
        int         dc;
        full_seq = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};

        rst_n = 1'b1; rst2_n = 1'b1;
        enable = 1'b0; enable2 = 1'b0; direction = 1'b1;
        stepMode = 2'b10; motorSpeed = 2'd3;
        moveStart = 1'b0; moveStart2 = 1'b0; moveSteps = 16'd0;

        // Reset state
        #2;
        rst_n = 1'b0; rst2_n = 1'b0;
        #1;
        check_val("rst_lights", 32'(lights), 32'h0);
        check_val("rst_pulse", 32'(stepPulse), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_done", 32'(moveDone), 32'h0);
        check_val("rst_pos", 32'(position), 32'h0);
        tick(); tick();
        rst_n = 1'b1; rst2_n = 1'b1;
        tick();
        check_val("idle_hold_lights", 32'(lights), 32'b1000);
        check_val("idle_free_lights2", 32'(lights2), 32'b0000);

        // 1: counted half-step move of 5
        stepMode = 2'b10; direction = 1'b1; motorSpeed = 2'd3;
        moveSteps = 16'd5; moveStart = 1'b1;
        push1(4'b1100, 16'd1, 0);
        push1(4'b0100, 16'd2, 2);
        push1(4'b0110, 16'd3, 2);
        push1(4'b0010, 16'd4, 2);
        push1(4'b0011, 16'd5, 2);
        tick();
        moveStart = 1'b0;
        check_val("t1_busy", 32'(busy), 32'd1);
        wait_done1("t1", 40);
        drain1("t1", 1);
        check_val("t1_pos", 32'(position), 32'd5);

        // 2: wave reverse run of 7 from idx 0
        rst_n = 1'b0;
        tick();
        check_val("t2_rst_pos", 32'(position), 32'd0);
        rst_n = 1'b1;
        stepMode = 2'b00; direction = 1'b0; enable = 1'b1;
        push1(4'b0001, 16'hFFFF, 0);
        push1(4'b0010, 16'hFFFE, 2);
        push1(4'b0100, 16'hFFFD, 2);
        push1(4'b1000, 16'hFFFC, 2);
        push1(4'b0001, 16'hFFFB, 2);
        push1(4'b0010, 16'hFFFA, 2);
        push1(4'b0100, 16'hFFF9, 2);
        drain1("t2", 40);
        enable = 1'b0;
        tick();
        check_val("t2_busy_off", 32'(busy), 32'd0);
        check_val("t2_pos", 32'(position), 32'hFFF9);
        check_val("t2_hold_lights", 32'(lights), 32'b0100);

        // 3: half step to idx 3, then switch to wave forward
        stepMode = 2'b10; direction = 1'b1; enable = 1'b1;
        push1(4'b0110, 16'hFFFA, 0);
        drain1("t3a", 20);
        stepMode = 2'b00;
        push1(4'b0010, 16'hFFFB, 2);
        push1(4'b0001, 16'hFFFC, 2);
        drain1("t3b", 20);
        enable = 1'b0;
        tick();

        // 4: speed 0 then speed 3 changed mid-interval
        stepMode = 2'b01; direction = 1'b1; motorSpeed = 2'd0; enable = 1'b1;
        push1(4'b1100, 16'hFFFD, 0);
        push1(4'b0110, 16'hFFFE, 16);
        drain1("t4a", 60);
        repeat (4) tick();
        motorSpeed = 2'd3;
        push1(4'b0011, 16'hFFFF, 16);
        push1(4'b1001, 16'h0000, 2);
        push1(4'b1100, 16'h0001, 2);
        drain1("t4b", 60);
        enable = 1'b0;
        tick();

        // 5a: zero-length move
        moveSteps = 16'd0; moveStart = 1'b1;
        tick();
        moveStart = 1'b0;
        check_val("t5a_busy", 32'(busy), 32'd1);
        check_val("t5a_done_early", 32'(moveDone), 32'd0);
        tick();
        check_val("t5a_done", 32'(moveDone), 32'd1);
        check_val("t5a_busy_off", 32'(busy), 32'd0);
        tick();
        check_val("t5a_done_1cyc", 32'(moveDone), 32'd0);
        check_val("t5a_pos", 32'(position), 32'd1);

        // 5b/5c: moveStart with enable wins; moveStart during move ignored
        stepMode = 2'b01; moveSteps = 16'd2; moveStart = 1'b1; enable = 1'b1;
        push1(4'b0110, 16'd2, 0);
        push1(4'b0011, 16'd3, 2);
        tick();
        moveStart = 1'b0; enable = 1'b0;
        tick();
        check_val("t5b_still_busy", 32'(busy), 32'd1);
        moveStart = 1'b1; moveSteps = 16'd7;
        tick();
        moveStart = 1'b0;
        wait_done1("t5b", 20);
        repeat (6) tick();
        drain1("t5b", 1);
        check_val("t5b_pos", 32'(position), 32'd3);
        check_val("t5b_idle", 32'(busy), 32'd0);

        // 6a: released coils, 4-bit position wrap after 17 steps
        check_val("t6_idle_lights2", 32'(lights2), 32'd0);
        stepMode = 2'b01; direction = 1'b1; motorSpeed = 2'd3; enable2 = 1'b1;
        for (int k = 0; k < 17; k++) begin
            push2(full_seq[k % 4], 16'((k + 1) % 16), (k == 0) ? 0 : 2);
        end
        drain2("t6a", 80);
        enable2 = 1'b0;
        tick();
        check_val("t6a_pos_wrap", 32'(position2), 32'd1);
        check_val("t6a_release", 32'(lights2), 32'd0);
        check_val("t6a_busy", 32'(busy2), 32'd0);

        // 6b: reset during a move aborts without moveDone
        moveSteps = 16'd10; moveStart2 = 1'b1;
        tick();
        moveStart2 = 1'b0;
        push2(4'b0011, 16'd2, 0);
        push2(4'b1001, 16'd3, 2);
        push2(4'b1100, 16'd4, 2);
        drain2("t6b", 20);
        rst2_n = 1'b0;
        #1;
        check_val("t6b_rst_lights", 32'(lights2), 32'd0);
        check_val("t6b_rst_pos", 32'(position2), 32'd0);
        check_val("t6b_rst_busy", 32'(busy2), 32'd0);
        check_val("t6b_rst_pulse", 32'(stepPulse2), 32'd0);
        check_val("t6b_rst_done", 32'(moveDone2), 32'd0);
        tick(); tick();
        rst2_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (moveDone2) dc++;
        end
        check_val("t6b_no_done", 32'(dc), 32'd0);
        check_val("t6b_idle", 32'(busy2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
